// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data memory arbiter: one request/response channel per port.
interface dmem_arbiter_if #(
  parameter int DataWidth = 32,
  parameter int Address   = 8
);
  logic                 req;
  logic                 we_re;
  logic [3:0]           mask;
  logic [Address-1:0]   addr;
  logic [DataWidth-1:0] wdata;
  logic                 gnt;
  logic                 rvalid;
  logic [DataWidth-1:0] rdata;
  logic                 rerr;

  modport master (
    output req, we_re, mask, addr, wdata,
    input  gnt, rvalid, rdata, rerr
  );

  modport slave (
    input  req, we_re, mask, addr, wdata,
    output gnt, rvalid, rdata, rerr
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing a single-ported data memory between the
// LSU (port 0) and DMA/debug (port 1); one read outstanding at a time.
module dmem_arbiter #(
  parameter int DataWidth = 32,
  parameter int Address   = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_arbiter_if.slave        io_req0,
  dmem_arbiter_if.slave        io_req1,
  output logic                 o_mem_request,
  output logic                 o_mem_we_re,
  output logic                 o_mem_load,
  output logic [3:0]           o_mem_mask,
  output logic [Address-1:0]   o_mem_address,
  output logic [DataWidth-1:0] o_mem_data_in,
  input  logic                 i_mem_valid,
  input  logic [DataWidth-1:0] i_mem_data_out,
  output logic                 o_busy
);

  // Counter holds 0..TIMEOUT-1; reaching the last value with no valid is the timeout.
  localparam int CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    RD_WAIT
  } state_t;

  state_t          r_state;
  logic            r_rr_ptr;
  logic            r_owner;
  logic [CntW-1:0] r_cnt;

  logic                 w_idle;
  logic                 w_wait;
  logic                 w_req0;
  logic                 w_req1;
  logic                 w_grant;
  logic                 w_win1;
  logic                 w_win_we;
  logic                 w_resp_ok;
  logic                 w_resp_to;
  logic                 w_resp;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_idle    = (r_state == IDLE) && !rst;
    w_wait    = (r_state == RD_WAIT) && !rst;
    w_req0    = w_idle && io_req0.req;
    w_req1    = w_idle && io_req1.req;
    w_grant   = w_req0 || w_req1;
    // Port 1 wins when alone, or when both ask and the pointer favours it.
    w_win1    = w_req1 && (!w_req0 || r_rr_ptr);
    w_win_we  = w_win1 ? io_req1.we_re : io_req0.we_re;
    w_resp_ok = w_wait && i_mem_valid;
    w_resp_to = w_wait && !i_mem_valid && (r_cnt == CntLast);
    w_resp    = w_resp_ok || w_resp_to;
  end

  // Memory pins are driven only while a grant is active, and are zero otherwise.
  always_comb begin
    o_mem_request = 1'b0;
    o_mem_we_re   = 1'b0;
    o_mem_load    = 1'b0;
    o_mem_mask    = 4'b0000;
    o_mem_address = '0;
    o_mem_data_in = '0;
    if (w_grant) begin
      o_mem_request = 1'b1;
      o_mem_we_re   = w_win_we;
      o_mem_load    = !w_win_we;
      if (w_win1) begin
        o_mem_mask    = io_req1.mask;
        o_mem_address = io_req1.addr;
        o_mem_data_in = io_req1.wdata;
      end else begin
        o_mem_mask    = io_req0.mask;
        o_mem_address = io_req0.addr;
        o_mem_data_in = io_req0.wdata;
      end
    end
  end

  assign io_req0.gnt    = w_grant && !w_win1;
  assign io_req1.gnt    = w_grant && w_win1;
  assign io_req0.rvalid = w_resp && !r_owner;
  assign io_req1.rvalid = w_resp && r_owner;
  assign io_req0.rerr   = w_resp_to && !r_owner;
  assign io_req1.rerr   = w_resp_to && r_owner;
  assign io_req0.rdata  = (w_resp_ok && !r_owner) ? i_mem_data_out : '0;
  assign io_req1.rdata  = (w_resp_ok && r_owner) ? i_mem_data_out : '0;
  assign o_busy         = w_wait;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rr_ptr <= 1'b0;
      r_owner  <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == IDLE) begin
      if (w_grant) begin
        r_rr_ptr <= !w_win1;
        if (!w_win_we) begin
          r_owner <= w_win1;
          r_cnt   <= '0;
          r_state <= RD_WAIT;
        end
      end
    end else begin
      if (w_resp) begin
        r_cnt   <= '0;
        r_state <= IDLE;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory with configurable read delay and a
// response scoreboard keyed by port, data, error flag and arrival cycle.
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DataWidth(DW), .Address(AW)) p0 ();
  dmem_arbiter_if #(.DataWidth(DW), .Address(AW)) p1 ();

  logic          mem_request, mem_we_re, mem_load, mem_valid, busy;
  logic [3:0]    mem_mask;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in, mem_data_out;

  dmem_arbiter #(.DataWidth(DW), .Address(AW), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .io_req0       (p0),
    .io_req1       (p1),
    .o_mem_request (mem_request),
    .o_mem_we_re   (mem_we_re),
    .o_mem_load    (mem_load),
    .o_mem_mask    (mem_mask),
    .o_mem_address (mem_address),
    .o_mem_data_in (mem_data_in),
    .i_mem_valid   (mem_valid),
    .i_mem_data_out(mem_data_out),
    .o_busy        (busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory: registered valid rd_delay cycles after load.
  logic [DW-1:0] mem [256];
  int            rd_delay = 1;
  logic          respond = 1'b1;
  logic          force_valid = 1'b0;
  int            pend_cnt = 0;
  logic [DW-1:0] pend_data;

  always @(posedge clk) begin
    mem_valid    <= 1'b0;
    mem_data_out <= '0;
    if (pend_cnt > 0) begin
      pend_cnt = pend_cnt - 1;
      if (pend_cnt == 0) begin
        mem_valid    <= 1'b1;
        mem_data_out <= pend_data;
      end
    end
    if (mem_request && mem_we_re) begin
      for (int b = 0; b < 4; b++)
        if (mem_mask[b]) mem[mem_address][8*b +: 8] <= mem_data_in[8*b +: 8];
    end else if (mem_load && respond) begin
      if (rd_delay <= 1) begin
        mem_valid    <= 1'b1;
        mem_data_out <= mem[mem_address];
      end else begin
        pend_cnt  = rd_delay - 1;
        pend_data = mem[mem_address];
      end
    end
    if (force_valid) begin
      mem_valid    <= 1'b1;
      mem_data_out <= 32'hBAD0BAD0;
    end
  end

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
    logic          err;
    int            cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [DW-1:0] own_data, other_data;
  logic          own_err, other_err;

  always @(negedge clk) begin
    if (p0.rvalid === 1'b1 || p1.rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: rvalid0=%b rvalid1=%b at cycle %0d, expected no response",
                 p0.rvalid, p1.rvalid, cyc);
      end else begin
        e = sb.pop_front();
        own_data   = e.port ? p1.rdata : p0.rdata;
        own_err    = e.port ? p1.rerr : p0.rerr;
        other_data = e.port ? p0.rdata : p1.rdata;
        other_err  = e.port ? p0.rerr : p1.rerr;
        checks++;
        if ({p1.rvalid, p0.rvalid} !== (e.port ? 2'b10 : 2'b01) || cyc != e.cyc) begin
          errors++;
          $display("FAIL rvalid_port_cycle: rvalid1/0=%b%b cycle=%0d, expected port %0d at cycle %0d",
                   p1.rvalid, p0.rvalid, cyc, e.port, e.cyc);
        end
        checks++;
        if ({own_data, own_err} !== {e.data, e.err}) begin
          errors++;
          $display("FAIL rdata_rerr: got data=%h err=%b, expected data=%h err=%b",
                   own_data, own_err, e.data, e.err);
        end
        checks++;
        if ({other_data, other_err} !== '0) begin
          errors++;
          $display("FAIL non_owner_quiet: got data=%h err=%b, expected 0", other_data, other_err);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_port(input logic p, input logic req, input logic we, input logic [3:0] m,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 1'b0) begin
      p0.req = req; p0.we_re = we; p0.mask = m; p0.addr = a; p0.wdata = d;
    end else begin
      p1.req = req; p1.we_re = we; p1.mask = m; p1.addr = a; p1.wdata = d;
    end
  endtask

  task automatic clear_ports();
    set_port(1'b0, 1'b0, 1'b0, 4'h0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, 4'h0, '0, '0);
  endtask

  task automatic push(input logic port, input logic [DW-1:0] d, input logic err, input int lat);
    sb.push_back('{port: port, data: d, err: err, cyc: cyc + lat});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_port(1'b0, 1'b1, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF);
    sample();
    checks++;
    if ({p0.gnt, p1.gnt, p0.rvalid, p1.rvalid, p0.rerr, p1.rerr,
         mem_request, mem_we_re, mem_load, busy} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl: gnt=%b%b rvalid=%b%b rerr=%b%b req/we/load/busy=%b%b%b%b, expected all 0",
               p0.gnt, p1.gnt, p0.rvalid, p1.rvalid, p0.rerr, p1.rerr, mem_request, mem_we_re, mem_load, busy);
    end
    checks++;
    if ({mem_mask, mem_address, mem_data_in, p0.rdata, p1.rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: mask=%h addr=%h din=%h rdata0=%h rdata1=%h, expected all 0",
               mem_mask, mem_address, mem_data_in, p0.rdata, p1.rdata);
    end
    step();
    rst = 1'b0;
    clear_ports();
    sample();
    checks++;
    if ({p0.gnt, p1.gnt, mem_request, mem_mask, busy} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: gnt=%b%b req=%b mask=%b busy=%b, expected 0",
               p0.gnt, p1.gnt, mem_request, mem_mask, busy);
    end
    step();
  endtask

  task automatic test_write_read();
    set_port(1'b0, 1'b1, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF);
    sample();
    checks++;
    if ({p0.gnt, p1.gnt, mem_request, mem_we_re, mem_load} !== 5'b10110 ||
        {mem_address, mem_data_in, mem_mask} !== {8'h10, 32'hDEADBEEF, 4'hF}) begin
      errors++;
      $display("FAIL write_grant: gnt=%b%b req/we/load=%b%b%b addr=%h din=%h mask=%h, expected 10 110 10 deadbeef f",
               p0.gnt, p1.gnt, mem_request, mem_we_re, mem_load, mem_address, mem_data_in, mem_mask);
    end
    step();
    set_port(1'b0, 1'b1, 1'b0, 4'h0, 8'h10, '0);
    sample();
    checks++;
    if ({p0.gnt, p1.gnt, mem_request, mem_we_re, mem_load} !== 5'b10101 || mem_address !== 8'h10) begin
      errors++;
      $display("FAIL read_grant: gnt=%b%b req/we/load=%b%b%b addr=%h, expected 10 101 10",
               p0.gnt, p1.gnt, mem_request, mem_we_re, mem_load, mem_address);
    end
    push(1'b0, 32'hDEADBEEF, 1'b0, 1);
    step();
    clear_ports();
    sample();
    checks++;
    if ({busy, mem_request, mem_load, mem_mask, mem_address, mem_data_in} !== {1'b1, 46'b0}) begin
      errors++;
      $display("FAIL rd_wait_outputs: busy=%b req=%b load=%b mask=%h addr=%h din=%h, expected busy only",
               busy, mem_request, mem_load, mem_mask, mem_address, mem_data_in);
    end
    step();
    sample();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_read: got %b, expected 0", busy);
    end
    step();
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] a0, a1, exp_addr;
    logic          exp_win;
    rst = 1'b1;
    step();
    rst = 1'b0;
    a0 = 8'h40;
    a1 = 8'h60;
    for (int i = 0; i < 8; i++) begin
      set_port(1'b0, 1'b1, 1'b1, 4'hF, a0, {24'h0, a0});
      set_port(1'b1, 1'b1, 1'b1, 4'hF, a1, {24'h0, a1});
      exp_win  = i[0];
      exp_addr = exp_win ? a1 : a0;
      sample();
      checks++;
      if ({p0.gnt, p1.gnt} !== (exp_win ? 2'b01 : 2'b10) || mem_address !== exp_addr ||
          mem_data_in !== {24'h0, exp_addr}) begin
        errors++;
        $display("FAIL rr_write_%0d: gnt0/1=%b%b addr=%h din=%h, expected port %0d addr=%h",
                 i, p0.gnt, p1.gnt, mem_address, mem_data_in, exp_win, exp_addr);
      end
      step();
      if (exp_win) a1 = a1 + 1'b1;
      else a0 = a0 + 1'b1;
    end
    clear_ports();
    set_port(1'b1, 1'b1, 1'b0, 4'h0, 8'h63, '0);
    sample();
    checks++;
    if ({p0.gnt, p1.gnt} !== 2'b01) begin
      errors++;
      $display("FAIL lone_req1_grant: gnt0/1=%b%b, expected 01", p0.gnt, p1.gnt);
    end
    push(1'b1, 32'h00000063, 1'b0, 1);
    step();
    clear_ports();
    sample();
    step();
  endtask

  task automatic test_back_to_back_reads();
    set_port(1'b0, 1'b1, 1'b0, 4'h0, 8'h30, '0);
    set_port(1'b1, 1'b1, 1'b0, 4'h0, 8'h31, '0);
    sample();
    checks++;
    if ({p0.gnt, p1.gnt, mem_load} !== 3'b101 || mem_address !== 8'h30) begin
      errors++;
      $display("FAIL dual_first: gnt0/1=%b%b load=%b addr=%h, expected 10 1 30",
               p0.gnt, p1.gnt, mem_load, mem_address);
    end
    push(1'b0, 32'hA5A50030, 1'b0, 1);
    step();
    set_port(1'b0, 1'b0, 1'b0, 4'h0, '0, '0);
    sample();
    checks++;
    if ({p0.gnt, p1.gnt, busy, mem_request} !== 4'b0010) begin
      errors++;
      $display("FAIL dual_wait1: gnt0/1=%b%b busy=%b req=%b, expected 00 1 0",
               p0.gnt, p1.gnt, busy, mem_request);
    end
    step();
    sample();
    checks++;
    if ({p0.gnt, p1.gnt, mem_load} !== 3'b011 || mem_address !== 8'h31) begin
      errors++;
      $display("FAIL dual_second: gnt0/1=%b%b load=%b addr=%h, expected 01 1 31",
               p0.gnt, p1.gnt, mem_load, mem_address);
    end
    push(1'b1, 32'h5A5A0031, 1'b0, 1);
    step();
    clear_ports();
    sample();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL dual_wait2: busy=%b, expected 1", busy);
    end
    step();
  endtask

  task automatic test_timeout();
    rd_delay = 16;
    set_port(1'b0, 1'b1, 1'b0, 4'h0, 8'h30, '0);
    sample();
    checks++;
    if (p0.gnt !== 1'b1) begin
      errors++;
      $display("FAIL timeout_grant: gnt0=%b, expected 1", p0.gnt);
    end
    push(1'b0, '0, 1'b1, TO);
    step();
    clear_ports();
    for (int k = 1; k <= TO; k++) begin
      sample();
      checks++;
      if ({busy, mem_request} !== 2'b10) begin
        errors++;
        $display("FAIL timeout_wait_%0d: busy=%b req=%b, expected 1 0", k, busy, mem_request);
      end
      step();
    end
    // A late valid lands in this idle cycle and must be ignored.
    set_port(1'b1, 1'b1, 1'b1, 4'hF, 8'h70, 32'h0BADF00D);
    sample();
    checks++;
    if ({p0.gnt, p1.gnt, p0.rvalid, p1.rvalid} !== 4'b0100) begin
      errors++;
      $display("FAIL after_timeout: gnt0/1=%b%b rvalid0/1=%b%b, expected 01 00",
               p0.gnt, p1.gnt, p0.rvalid, p1.rvalid);
    end
    step();
    clear_ports();
    rd_delay = 1;
  endtask

  task automatic test_valid_at_timeout();
    rd_delay = TO;
    set_port(1'b1, 1'b1, 1'b0, 4'h0, 8'h30, '0);
    sample();
    checks++;
    if (p1.gnt !== 1'b1) begin
      errors++;
      $display("FAIL tie_grant: gnt1=%b, expected 1", p1.gnt);
    end
    push(1'b1, 32'hA5A50030, 1'b0, TO);
    step();
    clear_ports();
    for (int k = 1; k <= TO; k++) begin
      sample();
      step();
    end
    sample();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL tie_done: busy=%b, expected 0", busy);
    end
    step();
    rd_delay = 1;
  endtask

  task automatic test_reset_mid_read();
    respond = 1'b0;
    set_port(1'b0, 1'b1, 1'b0, 4'h0, 8'h10, '0);
    sample();
    checks++;
    if (p0.gnt !== 1'b1) begin
      errors++;
      $display("FAIL midrst_grant: gnt0=%b, expected 1", p0.gnt);
    end
    step();
    clear_ports();
    rst = 1'b1;
    sample();
    checks++;
    if ({busy, p0.rvalid, p1.rvalid, p0.rerr, p1.rerr} !== 5'b0) begin
      errors++;
      $display("FAIL midrst_in_reset: busy=%b rvalid=%b%b rerr=%b%b, expected 0",
               busy, p0.rvalid, p1.rvalid, p0.rerr, p1.rerr);
    end
    step();
    rst = 1'b0;
    respond = 1'b1;
    force_valid = 1'b1;
    sample();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle: busy=%b, expected 0", busy);
    end
    step();
    force_valid = 1'b0;
    set_port(1'b0, 1'b1, 1'b1, 4'hF, 8'h80, 32'h11111111);
    set_port(1'b1, 1'b1, 1'b1, 4'hF, 8'h81, 32'h22222222);
    sample();
    checks++;
    if ({p0.gnt, p1.gnt, p0.rvalid, p1.rvalid} !== 4'b1000 || {p0.rdata, p1.rdata} !== '0) begin
      errors++;
      $display("FAIL midrst_after: gnt0/1=%b%b rvalid=%b%b rdata0=%h rdata1=%h, expected 10 00 0 0",
               p0.gnt, p1.gnt, p0.rvalid, p1.rvalid, p0.rdata, p1.rdata);
    end
    step();
    clear_ports();
  endtask

  task automatic test_mask();
    set_port(1'b1, 1'b1, 1'b1, 4'hF, 8'h20, 32'hFFFFFFFF);
    sample();
    checks++;
    if (p1.gnt !== 1'b1) begin
      errors++;
      $display("FAIL mask_fill_grant: gnt1=%b, expected 1", p1.gnt);
    end
    step();
    set_port(1'b1, 1'b1, 1'b1, 4'b0011, 8'h20, 32'h12345678);
    sample();
    checks++;
    if ({p1.gnt, mem_mask, mem_data_in} !== {1'b1, 4'b0011, 32'h12345678}) begin
      errors++;
      $display("FAIL mask_write: gnt1=%b mask=%b din=%h, expected 1 0011 12345678",
               p1.gnt, mem_mask, mem_data_in);
    end
    step();
    set_port(1'b1, 1'b1, 1'b0, 4'h0, 8'h20, '0);
    sample();
    checks++;
    if ({p1.gnt, mem_load} !== 2'b11) begin
      errors++;
      $display("FAIL mask_read_grant: gnt1=%b load=%b, expected 11", p1.gnt, mem_load);
    end
    push(1'b1, 32'hFFFF5678, 1'b0, 1);
    step();
    clear_ports();
    sample();
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h30] = 32'hA5A50030;
    mem[8'h31] = 32'h5A5A0031;
    clear_ports();
    rst = 1'b1;
    step();
    step();
    test_reset();
    test_write_read();
    test_round_robin();
    test_back_to_back_reads();
    test_timeout();
    test_valid_at_timeout();
    test_reset_mid_read();
    test_mask();
    step();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_responses: %0d outstanding, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
